hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage pipeline. Drives `stall` and `bubble` into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves:
- load-use hazards detected in ID;
- taken branches and jumps resolved at the EX/MEM register output;
- multi-cycle data-memory accesses, with a watchdog timeout.

It also keeps saturating stall and flush statistics counters.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/sat_counter.sv | 28 ++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard control.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Width of an architectural register number.
    localparam int REG_W = 5;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    localparam logic [REG_W-1:0] RNONE = '0;

    // Hazard controller states.
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline <-> hazard controller signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources observed in the pipeline.
    logic [pipe_ctrl_pkg::REG_W-1:0] id_rs;
    logic [pipe_ctrl_pkg::REG_W-1:0] id_rt;
    logic                            id_uses_rt;
    logic                            ex_MemtoReg;
    logic [pipe_ctrl_pkg::REG_W-1:0] ex_Rw;
    logic                            mem_Branch;
    logic                            mem_Zero;
    logic                            mem_Jump;
    logic                            dmem_req;
    logic                            dmem_ready;

    // Pipeline register / PC controls and status.
    logic             pc_stall;
    logic             pc_redirect;
    logic             ifid_stall;
    logic             ifid_bubble;
    logic             idex_stall;
    logic             idex_bubble;
    logic             exmem_stall;
    logic             exmem_bubble;
    logic             memwb_stall;
    logic             memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Pipeline side: supplies hazard sources, consumes controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemtoReg, ex_Rw,
               mem_Branch, mem_Zero, mem_Jump, dmem_req, dmem_ready,
        input  pc_stall, pc_redirect, ifid_stall, ifid_bubble,
               idex_stall, idex_bubble, exmem_stall, exmem_bubble,
               memwb_stall, memwb_bubble, mem_err, stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemtoReg, ex_Rw,
               mem_Branch, mem_Zero, mem_Jump, dmem_req, dmem_ready,
        output pc_stall, pc_redirect, ifid_stall, ifid_bubble,
               idex_stall, idex_bubble, exmem_stall, exmem_bubble,
               memwb_stall, memwb_bubble, mem_err, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    // Clear wins; otherwise count up until every bit is set.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Five-stage pipeline hazard controller: load-use stall,
//                taken branch/jump flush, data-memory wait with watchdog,
//                saturating stall/flush statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic    Clk,
    input  wire logic    Reset,
    hazard_ctrl_if.slave hz
);
    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_err_q;

    logic taken, lu, timeout, mhold;
    logic pc_stall, pc_redirect;
    logic ifid_stall, ifid_bubble, idex_stall, idex_bubble;
    logic exmem_stall, exmem_bubble, memwb_stall, memwb_bubble;
    logic stall_inc;

    // Raw hazard terms. The watchdog term drops mhold on the last permitted
    // wait cycle so the pipeline is forced forward.
    assign taken   = (hz.mem_Branch && hz.mem_Zero) || hz.mem_Jump;
    assign lu      = hz.ex_MemtoReg && (hz.ex_Rw != RNONE) &&
                     ((hz.ex_Rw == hz.id_rs) || (hz.id_uses_rt && (hz.ex_Rw == hz.id_rt)));
    assign timeout = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);
    assign mhold   = hz.dmem_req && !hz.dmem_ready && !timeout;

    // Priority decoder: one action per cycle, stall and bubble exclusive per register.
    always_comb begin
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        ifid_stall   = 1'b0;
        ifid_bubble  = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_stall  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_stall  = 1'b0;
        memwb_bubble = 1'b0;
        if (Reset || (state_q == INIT)) begin
            pc_stall     = 1'b1;
            ifid_bubble  = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mhold) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (taken) begin
            pc_redirect  = 1'b1;
            ifid_bubble  = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (lu) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_bubble  = 1'b1;
        end
    end

    // Controller FSM: one INIT cycle after reset, then track memory waits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= INIT;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: state_q <= RUN;
                RUN: begin
                    if (mhold) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (timeout) begin
                        mem_err_q <= 1'b1;
                    end
                    if (!mhold) begin
                        state_q <= RUN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Stalls are only counted once the pipeline is live (not the INIT flush).
    assign stall_inc = pc_stall && !Reset && ((state_q == RUN) || (state_q == MEM_WAIT));

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (Clk),
        .inc     (stall_inc),
        .clr     (Reset),
        .count_o (hz.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (Clk),
        .inc     (pc_redirect),
        .clr     (Reset),
        .count_o (hz.flush_count)
    );

    assign hz.pc_stall     = pc_stall;
    assign hz.pc_redirect  = pc_redirect;
    assign hz.ifid_stall   = ifid_stall;
    assign hz.ifid_bubble  = ifid_bubble;
    assign hz.idex_stall   = idex_stall;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_stall  = exmem_stall;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.memwb_stall  = memwb_stall;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.mem_err      = mem_err_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (vector table plus
//                multi-cycle sequences, expected controls via a queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Control vector order:
    // {pc_stall, pc_redirect, ifid_stall, ifid_bubble, idex_stall,
    //  idex_bubble, exmem_stall, exmem_bubble, memwb_stall, memwb_bubble}
    localparam logic [9:0] C_NONE  = 10'b0_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] C_INIT  = 10'b1_0_0_1_0_1_0_1_0_1;
    localparam logic [9:0] C_MHOLD = 10'b1_0_1_0_1_0_1_0_0_1;
    localparam logic [9:0] C_TAKEN = 10'b0_1_0_1_0_1_0_1_0_0;
    localparam logic [9:0] C_LU    = 10'b1_0_1_0_0_1_0_0_0_0;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       m2r;
        logic [4:0] rw;
        logic       br;
        logic       z;
        logic       j;
        logic       req;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;
    int   m_stall;
    int   m_flush;
    logic m_err;
    sb_t  sb[$];
    vec_t tbl[11];

    hazard_ctrl_if #(.CNT_W(16)) hz ();

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    wire logic [9:0] ctrl = {hz.pc_stall, hz.pc_redirect, hz.ifid_stall, hz.ifid_bubble,
                             hz.idex_stall, hz.idex_bubble, hz.exmem_stall, hz.exmem_bubble,
                             hz.memwb_stall, hz.memwb_bubble};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(string nm, logic rst, logic [4:0] rs, logic [4:0] rt,
                                logic urt, logic m2r, logic [4:0] rw, logic br, logic z,
                                logic j, logic req, logic rdy, logic [9:0] exp);
        vec_t v;
        v.name = nm; v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.m2r = m2r;
        v.rw = rw; v.br = br; v.z = z; v.j = j; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    // One clock cycle: check statistics (optional), drive inputs, queue the
    // expected controls, compare them mid-cycle, then advance the model.
    task automatic step(input vec_t v, input bit chk);
        sb_t e;
        @(posedge Clk);
        #1;
        if (chk) begin
            n_tests++;
            if (hz.stall_cycles !== 16'(m_stall)) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", v.name, hz.stall_cycles, m_stall);
            end
            n_tests++;
            if (hz.flush_count !== 16'(m_flush)) begin
                n_fail++;
                $display("FAIL %s flush_count: got %0d expected %0d", v.name, hz.flush_count, m_flush);
            end
            n_tests++;
            if (hz.mem_err !== m_err) begin
                n_fail++;
                $display("FAIL %s mem_err: got %b expected %b", v.name, hz.mem_err, m_err);
            end
        end
        Reset          = v.rst;
        hz.id_rs       = v.rs;
        hz.id_rt       = v.rt;
        hz.id_uses_rt  = v.urt;
        hz.ex_MemtoReg = v.m2r;
        hz.ex_Rw       = v.rw;
        hz.mem_Branch  = v.br;
        hz.mem_Zero    = v.z;
        hz.mem_Jump    = v.j;
        hz.dmem_req    = v.req;
        hz.dmem_ready  = v.rdy;
        sb.push_back('{name: v.name, exp: v.exp});
        @(negedge Clk);
        e = sb.pop_front();
        n_tests++;
        if (ctrl !== e.exp) begin
            n_fail++;
            $display("FAIL %s controls: got %b expected %b", e.name, ctrl, e.exp);
        end
        if (v.rst) begin
            m_stall = 0;
            m_flush = 0;
            m_err   = 1'b0;
        end else if (v.exp != C_INIT) begin
            m_stall += int'(v.exp[9]);
            m_flush += int'(v.exp[8]);
        end
    endtask

    initial begin
        vec_t idle, rst_v, hold, rdy_v;
        n_tests = 0;
        n_fail  = 0;
        m_stall = 0;
        m_flush = 0;
        m_err   = 1'b0;
        Reset   = 1'b1;
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_MemtoReg = 1'b0;
        hz.ex_Rw = '0; hz.mem_Branch = 1'b0; hz.mem_Zero = 1'b0; hz.mem_Jump = 1'b0;
        hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;

        idle  = mk("idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);
        rst_v = mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT);
        hold  = mk("mhold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MHOLD);
        rdy_v = mk("ready", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE);

        tbl[0]  = mk("idle_run",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);
        tbl[1]  = mk("lu_rs",         0, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, C_LU);
        tbl[2]  = mk("lu_r0",         0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_NONE);
        tbl[3]  = mk("lu_rt",         0, 3, 7, 1, 1, 7, 0, 0, 0, 0, 0, C_LU);
        tbl[4]  = mk("rt_unused",     0, 3, 7, 0, 1, 7, 0, 0, 0, 0, 0, C_NONE);
        tbl[5]  = mk("not_load",      0, 5, 0, 0, 0, 5, 0, 0, 0, 0, 0, C_NONE);
        tbl[6]  = mk("branch_taken",  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, C_TAKEN);
        tbl[7]  = mk("branch_nt",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_NONE);
        tbl[8]  = mk("jump",          0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_TAKEN);
        tbl[9]  = mk("taken_over_lu", 0, 5, 0, 0, 1, 5, 0, 0, 1, 0, 0, C_TAKEN);
        tbl[10] = mk("mem_ready_now", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE);

        // Reset held 3 cycles, then one INIT cycle, then live.
        for (int i = 0; i < 3; i++) step(rst_v, i == 0);
        step(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT), 1'b0);
        step(idle, 1'b1);

        // Single-cycle decode table.
        for (int i = 0; i < 11; i++) step(tbl[i], 1'b0);
        step(idle, 1'b1);

        // Memory ready 4 cycles late, from a clean reset.
        step(rst_v, 1'b0);
        step(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT), 1'b0);
        for (int i = 0; i < 4; i++) step(hold, 1'b0);
        step(rdy_v, 1'b0);
        step(idle, 1'b1);

        // Memory never ready: 16 stall cycles, then forced through.
        for (int i = 0; i < 16; i++) step(hold, 1'b0);
        step(mk("timeout", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE), 1'b0);
        m_err = 1'b1;
        step(idle, 1'b1);

        // Taken branch during a memory wait: wait first, redirect when it ends.
        for (int i = 0; i < 2; i++)
            step(mk("taken_mhold", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, C_MHOLD), 1'b0);
        step(mk("taken_after_wait", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, C_TAKEN), 1'b0);
        step(idle, 1'b1);

        // Reset in the middle of a wait clears error and statistics.
        for (int i = 0; i < 2; i++) step(hold, 1'b0);
        step(mk("reset_mid_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_INIT), 1'b0);
        step(mk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT), 1'b0);
        step(idle, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
